alu_status_register: RTL and testbench

Registered NZCV status block sitting directly downstream of the ALU and its flag generators. It latches the ALU result's sign and zero, plus the carry and overflow flags, on every accepted ALU operation. It keeps a sticky overflow bit and a saturating overflow-event counter. It answers condition-code queries from the control unit through a req/ack handshake.

---
 rtl/alu_status_register.sv | 141 ++++++++++++++
 tb/tb_alu_status_register.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_status_register.sv
// Registered NZCV flags, sticky overflow and saturating overflow counter behind the ALU, plus a condition-code query port.
// Latency: flags visible 1 cycle after an accepted update; a query answer is valid 2 cycles after cond_req.
// Backpressure: alu_ready drops only while a query is being evaluated; the answer is held until cond_ack.
module alu_status_register #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [WIDTH-1:0]     result,
    input  logic                 carry,
    input  logic                 overflow,
    input  logic [1:0]           control,
    input  logic                 sticky_clr,
    input  logic                 cond_req,
    input  logic [3:0]           cond_code,
    output logic                 cond_valid,
    output logic                 cond_true,
    input  logic                 cond_ack,
    output logic                 flag_n,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic                 flag_v,
    output logic                 sticky_v,
    output logic [CNT_WIDTH-1:0] ovf_count
);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] code_q;
    logic       cond_eval;
    logic       upd;
    logic       ovf_ev;
    logic       is_logic;

    assign is_logic = control[1];
    assign upd      = alu_valid && alu_ready;
    assign ovf_ev   = upd && !is_logic && overflow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cond_req) state_nxt = EVAL;
            EVAL:    state_nxt = RESP;
            RESP:    if (cond_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_ready  = (state != EVAL);
        cond_valid = (state == RESP);
    end

    // EVAL reads the flag registers, so an update accepted alongside cond_req is already visible.
    always_comb begin
        cond_eval = 1'b0;
        case (code_q)
            4'd0:  cond_eval = flag_z;
            4'd1:  cond_eval = !flag_z;
            4'd2:  cond_eval = flag_c;
            4'd3:  cond_eval = !flag_c;
            4'd4:  cond_eval = flag_n;
            4'd5:  cond_eval = !flag_n;
            4'd6:  cond_eval = flag_v;
            4'd7:  cond_eval = !flag_v;
            4'd8:  cond_eval = flag_c && !flag_z;
            4'd9:  cond_eval = !flag_c || flag_z;
            4'd10: cond_eval = (flag_n == flag_v);
            4'd11: cond_eval = (flag_n != flag_v);
            4'd12: cond_eval = !flag_z && (flag_n == flag_v);
            4'd13: cond_eval = flag_z || (flag_n != flag_v);
            4'd14: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q    <= 4'd0;
            cond_true <= 1'b0;
        end else begin
            if (state == IDLE && cond_req) begin
                code_q <= cond_code;
            end
            if (state == EVAL) begin
                cond_true <= cond_eval;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else if (upd) begin
            flag_n <= result[WIDTH-1];
            flag_z <= (result == '0);
            if (is_logic) begin
                flag_v <= 1'b0;
            end else begin
                flag_c <= carry;
                flag_v <= overflow;
            end
        end
    end

    // A new overflow event beats a simultaneous clear for both sticky_v and the counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_v  <= 1'b0;
            ovf_count <= '0;
        end else begin
            if (ovf_ev) begin
                sticky_v <= 1'b1;
            end else if (sticky_clr) begin
                sticky_v <= 1'b0;
            end
            if (sticky_clr) begin
                ovf_count <= ovf_ev ? CNT_WIDTH'(1) : '0;
            end else if (ovf_ev && (ovf_count != '1)) begin
                ovf_count <= ovf_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_status_register.sv
// Randomized scoreboard bench for alu_status_register with a behavioural flag/query model.
module tb_alu_status_register;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid;
    logic          alu_ready;
    logic [W-1:0]  result;
    logic          carry;
    logic          overflow;
    logic [1:0]    control;
    logic          sticky_clr;
    logic          cond_req;
    logic [3:0]    cond_code;
    logic          cond_valid;
    logic          cond_true;
    logic          cond_ack;
    logic          flag_n, flag_z, flag_c, flag_v;
    logic          sticky_v;
    logic [CW-1:0] ovf_count;

    always #5 clk = ~clk;

    alu_status_register #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_ready(alu_ready),
        .result(result), .carry(carry), .overflow(overflow), .control(control),
        .sticky_clr(sticky_clr), .cond_req(cond_req), .cond_code(cond_code),
        .cond_valid(cond_valid), .cond_true(cond_true), .cond_ack(cond_ack),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .sticky_v(sticky_v), .ovf_count(ovf_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: flags, sticky bit, event count and query progress (0 idle, 1 evaluating, 2 answering).
    logic       mn = 0, mz = 0, mc = 0, mv = 0, ms = 0;
    int         mcnt = 0;
    int         phase = 0;
    logic [3:0] mcode = 0;
    logic       exp_q[$];
    logic       mon_en = 1'b0;
    logic       prev_vld = 1'b0;
    logic       held = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cond_ref(input logic [3:0] c, input logic n, input logic z,
                                      input logic cy, input logic v);
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_update();
        logic acc, ev;
        int   maxc;
        maxc = (1 << CW) - 1;
        if (!rst_n) begin
            mn = 0; mz = 0; mc = 0; mv = 0; ms = 0; mcnt = 0; phase = 0;
            exp_q.delete();
            return;
        end
        acc = alu_valid && (phase != 1);
        ev  = acc && !control[1] && overflow;
        case (phase)
            0: if (cond_req) begin mcode = cond_code; phase = 1; end
            1: begin exp_q.push_back(cond_ref(mcode, mn, mz, mc, mv)); phase = 2; end
            default: if (cond_ack) phase = 0;
        endcase
        if (acc) begin
            mn = result[W-1];
            mz = (result == 0);
            if (control[1]) mv = 0;
            else begin mc = carry; mv = overflow; end
        end
        if (ev) ms = 1;
        else if (sticky_clr) ms = 0;
        if (sticky_clr) mcnt = ev ? 1 : 0;
        else if (ev && mcnt < maxc) mcnt++;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("flags_nzcv", {flag_n, flag_z, flag_c, flag_v}, {mn, mz, mc, mv});
            check("sticky_v", sticky_v, ms);
            check("ovf_count", ovf_count, mcnt);
            check("alu_ready", alu_ready, phase != 1);
            check("cond_valid", cond_valid, phase == 2);
            if (cond_valid && !prev_vld) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected actual=valid expected=no_pending_query at %0t", $time);
                end else begin
                    held = exp_q.pop_front();
                    check("cond_true", cond_true, held);
                end
            end else if (cond_valid) begin
                check("cond_true_hold", cond_true, held);
            end
            prev_vld = cond_valid;
        end
    end

    task automatic idle_in();
        alu_valid = 0; result = 0; carry = 0; overflow = 0; control = 0;
        sticky_clr = 0; cond_req = 0; cond_code = 0; cond_ack = 0;
    endtask

    task automatic alu_op(input logic [1:0] ctl, input logic [W-1:0] res,
                          input logic cy, input logic ov, input logic clr);
        alu_valid = 1; control = ctl; result = res; carry = cy; overflow = ov; sticky_clr = clr;
        step();
        idle_in();
    endtask

    // Issues a query, holds the answer for ack_dly cycles while poking ignored inputs, returns the held answer.
    task automatic query(input logic [3:0] code, input int ack_dly, output logic ans);
        cond_req = 1; cond_code = code;
        step();
        cond_req = 0;
        alu_valid = 1; control = 2'b00; result = 4'b0111; carry = 1; overflow = 1;
        step();
        idle_in();
        for (int i = 0; i < ack_dly; i++) begin
            cond_req = 1; cond_code = ~code;
            step();
        end
        cond_req = 0;
        ans = cond_true;
        cond_ack = 1;
        step();
        cond_ack = 0;
    endtask

    logic ans;

    initial begin
        rst_n = 0;
        alu_valid = 1'($urandom); result = W'($urandom); carry = 1'($urandom);
        overflow = 1'($urandom); control = 2'($urandom); sticky_clr = 1'($urandom);
        cond_req = 1'($urandom); cond_code = 4'($urandom); cond_ack = 1'($urandom);
        step();
        mon_en = 1;
        step();
        check("rst_flags", {flag_n, flag_z, flag_c, flag_v}, 4'b0000);
        check("rst_count", {sticky_v, 2'(ovf_count)}, 3'b000);
        check("rst_ready_valid", {alu_ready, cond_valid}, 2'b10);
        idle_in();
        rst_n = 1;
        step();

        alu_op(2'b00, 4'b1000, 0, 1, 0);
        check("add_ovf_flags", {flag_n, flag_z, flag_c, flag_v}, 4'b1001);
        check("add_ovf_sticky_cnt", {sticky_v, 2'(ovf_count)}, 3'b101);
        query(4'd10, 0, ans);
        check("query_ge", ans, 1);

        alu_op(2'b10, 4'b0000, 1, 1, 0);
        check("logic_flags", {flag_n, flag_z, flag_c, flag_v}, 4'b0100);
        check("logic_cnt", ovf_count, 1);
        query(4'd0, 1, ans);
        check("query_eq", ans, 1);
        query(4'd6, 0, ans);
        check("query_vs", ans, 0);

        for (int i = 0; i < 5; i++) alu_op(2'b01, 4'b0110, 0, 1, 0);
        check("sat_count", ovf_count, 3);
        alu_op(2'b01, 4'b0001, 1, 1, 1);
        check("clr_race", {sticky_v, 2'(ovf_count)}, 3'b101);
        query(4'd8, 4, ans);
        check("query_hi_held", ans, 1);

        cond_req = 1; cond_code = 4'd14;
        step();
        cond_req = 0;
        step();
        check("resp_before_rst", cond_valid, 1);
        rst_n = 0;
        step();
        rst_n = 1;
        check("rst_in_resp_valid", cond_valid, 0);
        check("rst_in_resp_flags", {flag_n, flag_z, flag_c, flag_v, sticky_v}, 5'b00000);
        step();

        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            alu_valid  = 1'($urandom);
            result     = W'($urandom);
            carry      = 1'($urandom);
            overflow   = 1'($urandom);
            control    = 2'($urandom);
            sticky_clr = ($urandom_range(0, 15) == 0);
            cond_req   = 1'($urandom);
            cond_code  = 4'($urandom);
            cond_ack   = ($urandom_range(0, 2) == 0);
            step();
        end
        idle_in();
        rst_n = 1;
        cond_ack = 1;
        repeat (4) step();
        cond_ack = 0;
        step();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
